shift_seq: RTL and testbench
============================

Name: shift_seq

Overview:
- Multi-cycle shift/rotate sequencer that reuses a single conditional power-of-two shift stage once per cycle. It processes one bit of the shift amount per step, LSB first.
- Replaces the four-level combinational barrel shifter where area or timing matters. It sits beside the ALU and is driven by the execute stage through a start/busy/done handshake.
- Supports the ISA shift group: rotate left, shift left logical, rotate right and shift right logical.

Parameters:
- WIDTH, 16, operand width. Must be a power of two, 4 or more. Localparam AW = log2(WIDTH) is the shift-amount width and the number of steps.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation. Sampled only when not busy.
- op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL.
- in  input  WIDTH  operand.
- cnt  input  AW  shift amount, 0..WIDTH-1.
- out  output  WIDTH  accumulator register. Valid when done=1 and held until the next accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when out holds the final result.

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values: rst=1 at an edge forces state=IDLE, out=0, busy=0, done=0 and step=0. Reset has priority over everything else, including mid-operation; any partial result is discarded.
- State IDLE:
  - busy=0, done=0.
  - start=1 → load acc=in, amt=cnt, opr=op, step=0, then go to RUN.
- State RUN:
  - busy=1.
  - Each edge: if amt[step]=1, apply a shift of 2^step to acc per opr; otherwise acc is unchanged. Then step increments.
  - After step=AW-1 is processed → DONE.
  - start is ignored while in RUN; in, op and cnt are don't-care.
- State DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge: start=1 → load and go to RUN (back-to-back operation). Otherwise → IDLE.
- Stage arithmetic:
  - ROL: acc = {acc[W-1-s:0], acc[W-1:W-s]}.
  - ROR: mirror of ROL.
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - Rotates wrap with no bit loss. Logical shifts discard bits shifted out.
- Latency (base build): start sampled at edge E0 → RUN on edges E1..E_AW → done sampled high at edge E(AW+1). For WIDTH=16 this is 5 edges, independent of cnt.
- Boundary cases:
  - cnt=0 still takes the full latency; out=in.
  - cnt=WIDTH-1 is the maximum amount.
- out shows intermediate values during RUN. Consumers must use out only with done or after done.

Optional Feature:
- Macro: SHIFT_SEQ_EARLY_DONE_EN.
- When defined, early termination applies:
  - On the accepting edge, if cnt=0, go straight to DONE with acc=in (done at E1).
  - In RUN, after processing step k, if amt[AW-1:k+1]=0, go to DONE immediately.
  - Latency = (index of the highest set bit of cnt) + 2 edges.
- When undefined: fixed AW+1 edge latency as above.
- Results are identical in both builds.

Test Plan:
- ROL, in=0x8001, cnt=4, single start → out=0x0018. busy high for 4 cycles. done is a single pulse sampled at E5; out stays 0x0018 afterwards.
- SRL, in=0x8000, cnt=15 → out=0x0001. Then back-to-back start in the DONE cycle with SLL, in=0x0001, cnt=15 → out=0x8000 at E5 of the second operation, with no IDLE cycle between.
- ROR, in=0x1234, cnt=4 → 0x4123. ROR, in=0x1234, cnt=0 → 0x1234, with latency still 5 in the base build.
- Busy guard: start ROL 0x00FF cnt=8, then pulse start with SLL 0xFFFF cnt=1 at E2 → out=0xFF00. Exactly one done pulse; the second request is not captured.
- Reset mid-op: start SLL 0x0003 cnt=5, assert rst at E3 → after that edge, out=0x0000, busy=0, done=0. A new ROL 0x0001 cnt=1 then yields 0x0002 normally.
- With SHIFT_SEQ_EARLY_DONE_EN:
  - cnt=0 → done at E1.
  - cnt=1 → done at E2.
  - cnt=3 → done at E3.
  - cnt=8 → done at E5.
  - Results match the base build.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq -- multi-cycle shift/rotate sequencer.
//
// Reuses one conditional power-of-two shift stage per clock. Each step
// handles one bit of the shift amount, LSB first, so an operation takes
// AW = log2(WIDTH) RUN cycles instead of a full combinational barrel.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   start  in   request a new operation (sampled only when not busy)
//   op     in   2'b00 ROL, 2'b01 SLL, 2'b10 ROR, 2'b11 SRL
//   in     in   WIDTH-bit operand
//   cnt    in   AW-bit shift amount
//   out    out  accumulator; final result while done=1, held until next start
//   busy   out  high while sequencing
//   done   out  one-cycle pulse when out holds the final result
//
// Optional build macro: SHIFT_SEQ_EARLY_DONE_EN
//   Finish as soon as no higher amount bits remain set (cnt=0 goes straight
//   to DONE). Results are identical; only latency changes.
module shift_seq #(
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    cnt,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AW-1:0]    amt_q, amt_d;
  logic [1:0]       opr_q, opr_d;
  logic [AW-1:0]    step_q, step_d;

  // Single shift stage: distance 2^step_q, at most WIDTH/2, so it fits AW bits.
  logic [AW-1:0]    sh;
  logic [AW:0]      sh_c;     // WIDTH - sh, the complementary distance for rotates
  logic [WIDTH-1:0] stage;
  logic             last_step;

  always_comb begin
    sh   = AW'(1) << step_q;
    sh_c = (AW+1)'(WIDTH) - {1'b0, sh};
    case (opr_q)
      OP_ROL:  stage = (acc_q << sh) | (acc_q >> sh_c);
      OP_SLL:  stage = acc_q << sh;
      OP_ROR:  stage = (acc_q >> sh) | (acc_q << sh_c);
      default: stage = acc_q >> sh;
    endcase
  end

`ifdef SHIFT_SEQ_EARLY_DONE_EN
  // Stop once no amount bit above the current step is set.
  assign last_step = (step_q == AW'(AW-1)) || (((amt_q >> step_q) >> 1) == '0);
`else
  assign last_step = (step_q == AW'(AW-1));
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    opr_d   = opr_q;
    step_d  = step_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          acc_d   = in;
          amt_d   = cnt;
          opr_d   = op;
          step_d  = '0;
          state_d = RUN;
`ifdef SHIFT_SEQ_EARLY_DONE_EN
          if (cnt == '0) state_d = DONE;
`endif
        end
      end
      RUN: begin
        if (amt_q[step_q]) acc_d = stage;
        step_d = step_q + AW'(1);
        if (last_step) begin
          state_d = DONE;
          step_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      opr_q   <= OP_ROL;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      opr_q   <= opr_d;
      step_q  <= step_d;
    end
  end

  assign out  = acc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Testbench for shift_seq (WIDTH=16). A behavioural model tracks expected
// result and timing per operation; a negedge monitor compares busy/done
// every cycle and out whenever it is defined. Directed cases pin literal
// results and latencies; a random phase follows.
module tb_shift_seq;
  localparam int W  = 16;
  localparam int AW = 4;
`ifdef SHIFT_SEQ_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start;
  logic [1:0]    op;
  logic [W-1:0]  in_d, out_d;
  logic [AW-1:0] cnt;
  logic          busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in(in_d), .cnt(cnt),
    .out(out_d), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference result: apply cnt single-bit moves.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] d,
                                             input logic [AW-1:0] c);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < int'(c); i++) begin
      case (o)
        2'b00:   r = {r[W-2:0], r[W-1]};
        2'b01:   r = r << 1;
        2'b10:   r = {r[0], r[W-1:1]};
        default: r = r >> 1;
      endcase
    end
    return r;
  endfunction

  // Number of busy cycles an operation occupies.
  function automatic int run_cycles(input logic [AW-1:0] c);
    int hi;
    if (!EARLY) return AW;
    hi = -1;
    for (int i = 0; i < AW; i++) if (c[i]) hi = i;
    return hi + 1;
  endfunction

  // Model state
  bit           m_init = 0;
  int           m_left = 0;
  bit           m_done = 0;
  bit           m_outv = 0;
  logic [W-1:0] m_res  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_left = 0; m_done = 0; m_res = '0; m_outv = 1;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      m_outv = m_done;
    end else if (start) begin
      m_res  = ref_shift(op, in_d, cnt);
      m_left = run_cycles(cnt);
      m_done = (m_left == 0);
      m_outv = m_done;
    end else begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("busy", {31'd0, busy}, {31'd0, m_left > 0});
      check("done", {31'd0, done}, {31'd0, m_done});
      if (m_outv) check("out", {16'd0, out_d}, {16'd0, m_res});
    end
  end

  // Issue one op from a negedge; returns at the negedge where done is seen.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] d, input logic [AW-1:0] c,
                       input logic [W-1:0] exp_out, input int exp_lat, input string name);
    int n;
    op = o; in_d = d; cnt = c; start = 1'b1;
    @(posedge clk); n = 1;
    @(negedge clk); start = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    check({name, "_lat"}, n, exp_lat);
    check({name, "_out"}, {16'd0, out_d}, {16'd0, exp_out});
  endtask

  initial begin
    int ndone;
    logic [W-1:0] got;
    rst = 1'b1; start = 1'b0; op = 2'b00; in_d = '0; cnt = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_out", {16'd0, out_d}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_done", {31'd0, done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_op(2'b00, 16'h8001, 4'd4, 16'h0018, EARLY ? 4 : 5, "rol4");
    repeat (3) @(negedge clk);
    check("rol4_hold", {16'd0, out_d}, 32'h0018);
    check("rol4_single", {31'd0, done}, 32'h0);

    do_op(2'b11, 16'h8000, 4'd15, 16'h0001, 5, "srl15");
    do_op(2'b01, 16'h0001, 4'd15, 16'h8000, 5, "sll15_b2b");
    do_op(2'b10, 16'h1234, 4'd4,  16'h4123, EARLY ? 4 : 5, "ror4");
    do_op(2'b10, 16'h1234, 4'd0,  16'h1234, EARLY ? 1 : 5, "ror0");
    do_op(2'b00, 16'h0001, 4'd1,  16'h0002, EARLY ? 2 : 5, "rol1");
    do_op(2'b00, 16'h0001, 4'd3,  16'h0008, EARLY ? 3 : 5, "rol3");
    do_op(2'b00, 16'h0001, 4'd8,  16'h0100, 5, "rol8");
    @(negedge clk);

    // Busy guard: second request at E2 must be ignored.
    op = 2'b00; in_d = 16'h00FF; cnt = 4'd8; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    @(posedge clk); @(negedge clk);
    op = 2'b01; in_d = 16'hFFFF; cnt = 4'd1; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    ndone = 0; got = '0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin ndone++; got = out_d; end
      @(negedge clk);
    end
    check("guard_pulses", ndone, 1);
    check("guard_out", {16'd0, got}, 32'hFF00);

    // Reset mid-operation at E3.
    op = 2'b01; in_d = 16'h0003; cnt = 4'd5; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_out", {16'd0, out_d}, 32'h0);
    check("midrst_busy", {31'd0, busy}, 32'h0);
    check("midrst_done", {31'd0, done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    do_op(2'b00, 16'h0001, 4'd1, 16'h0002, EARLY ? 2 : 5, "post_rst");

    // Random phase; the monitor does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom_range(0, 3));
      in_d  = 16'($urandom);
      cnt   = 4'($urandom_range(0, 15));
      rst   = ($urandom_range(0, 255) == 0);
    end
    @(negedge clk); start = 1'b0; rst = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
